// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I core.
// Accepts one load/store request at a time over a valid/ready handshake and
// answers with a single-cycle response pulse after a fixed number of wait
// states. Stores write only the addressed byte lanes. Loads return sign- or
// zero-extended data. Rejected requests return rsp_err=1 with zero data and
// leave the array untouched.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,  // 32-bit words in the array, power of 2, >= 4
   parameter int WAIT_CYCLES = 1     // extra cycles between accept and response, 0..15
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   // Counter preload for the WAIT state; unused when there are no wait states.
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   // RV32I load/store width codes.
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state;
   logic [3:0]  wait_cnt;

   // Request captured at accept.
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic        accept;
   logic        enter_resp;

   // Request being evaluated on the edge that enters RESP.
   logic        use_live;
   logic        cur_we;
   logic [2:0]  cur_funct3;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;
   logic [IDX_W-1:0] cur_idx;

   logic        cur_err;
   logic [3:0]  cur_be;
   logic [31:0] cur_wlanes;
   logic        mem_we;

   logic [31:0] rd_word;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_data;

   // Ready is forced low while reset is held, and otherwise tracks IDLE directly
   // so that a request can be taken in the very first cycle after release.
   assign req_ready = reset_n && (state == ST_IDLE);
   assign accept    = req_valid && req_ready;

   // With no wait states RESP is entered on the accept edge itself; otherwise on
   // the edge where the wait counter has run out.
   assign enter_resp = ((state == ST_WAIT) && (wait_cnt == 4'd0)) ||
                       (accept && (WAIT_CYCLES == 0));

   // On the accept edge the latch has not been loaded yet, so the live request
   // is evaluated directly; in every other state the captured copy is used.
   assign use_live   = (state == ST_IDLE);
   assign cur_we     = use_live ? req_we     : we_q;
   assign cur_funct3 = use_live ? req_funct3 : funct3_q;
   assign cur_addr   = use_live ? req_addr   : addr_q;
   assign cur_wdata  = use_live ? req_wdata  : wdata_q;
   assign cur_idx    = cur_addr[IDX_W+1:2];

   // Reject misaligned, out-of-range and illegal width codes.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
      cur_err = 1'b0;
      unique case (cur_funct3)
         F3_B:          cur_err = 1'b0;
         F3_H:          cur_err = cur_addr[0];
         F3_W:          cur_err = |cur_addr[1:0];
         F3_BU, F3_HU:  cur_err = cur_we || (cur_funct3[0] && cur_addr[0]);
         default:       cur_err = 1'b1;
      endcase
      if (cur_addr[31:2] >= 30'(DEPTH_WORDS)) begin
         cur_err = 1'b1;
      end
   end

   // Byte-lane enables and lane-replicated store data for the addressed width.
   always_comb begin
      cur_be     = 4'b1111;
      cur_wlanes = cur_wdata;
      unique case (cur_funct3[1:0])
         2'b00: begin
            cur_be     = 4'b0001 << cur_addr[1:0];
            cur_wlanes = {4{cur_wdata[7:0]}};
         end
         2'b01: begin
            cur_be     = cur_addr[1] ? 4'b1100 : 4'b0011;
            cur_wlanes = {2{cur_wdata[15:0]}};
         end
         default: begin
            cur_be     = 4'b1111;
            cur_wlanes = cur_wdata;
         end
      endcase
   end

   assign mem_we = enter_resp && cur_we && !cur_err;

   // Select and extend the addressed byte/half of the stored word. A request is
   // either a load or a store, so a load never races its own commit.
   assign rd_word = mem[cur_idx];

   always_comb begin
      rd_byte = rd_word[7:0];
      unique case (cur_addr[1:0])
         2'd0: rd_byte = rd_word[7:0];
         2'd1: rd_byte = rd_word[15:8];
         2'd2: rd_byte = rd_word[23:16];
         2'd3: rd_byte = rd_word[31:24];
      endcase
      rd_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

      load_data = 32'd0;
      unique case (cur_funct3)
         F3_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
         F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
         F3_W:    load_data = rd_word;
         F3_BU:   load_data = {24'd0, rd_byte};
         F3_HU:   load_data = {16'd0, rd_half};
         default: load_data = 32'd0;
      endcase
   end

   // Byte-lane store commit on the edge that enters RESP.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; only control state is reset, and write enables are qualified by that state.
      if (mem_we) begin
         for (int lane = 0; lane < 4; lane++) begin
            if (cur_be[lane]) begin
               mem[cur_idx][8*lane +: 8] <= cur_wlanes[8*lane +: 8];
            end
         end
      end
   end

   // Control FSM with registered response outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         wait_cnt  <= 4'd0;
         we_q      <= 1'b0;
         funct3_q  <= 3'd0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;

         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  we_q     <= req_we;
                  funct3_q <= req_funct3;
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  if (WAIT_CYCLES == 0) begin
                     state <= ST_RESP;
                  end else begin
                     state    <= ST_WAIT;
                     wait_cnt <= WAIT_LOAD;
                  end
               end
            end
            ST_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase

         if (enter_resp) begin
            rsp_valid <= 1'b1;
            rsp_err   <= cur_err;
            rsp_rdata <= (cur_we || cur_err) ? 32'd0 : load_data;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with one wait state and one with none,
// directed scenarios followed by randomized traffic checked against a
// byte-addressed reference memory.
module tb_dmem_responder;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   // Instance index 0 has WAIT_CYCLES=0, index 1 has WAIT_CYCLES=1.
   logic        v_0 = 1'b0, we_0 = 1'b0, v_1 = 1'b0, we_1 = 1'b0;
   logic [2:0]  f3_0 = 3'd0, f3_1 = 3'd0;
   logic [31:0] a_0 = 32'd0, d_0 = 32'd0, a_1 = 32'd0, d_1 = 32'd0;
   logic        rdy_0, rv_0, err_0, rdy_1, rv_1, err_1;
   logic [31:0] rd_0, rd_1;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // Reference memory: one byte per address, per instance.
   logic [7:0] bmem [2][1024];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_w0 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(v_0), .req_ready(rdy_0), .req_we(we_0), .req_funct3(f3_0),
      .req_addr(a_0), .req_wdata(d_0),
      .rsp_valid(rv_0), .rsp_rdata(rd_0), .rsp_err(err_0)
   );

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut_w1 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(v_1), .req_ready(rdy_1), .req_we(we_1), .req_funct3(f3_1),
      .req_addr(a_1), .req_wdata(d_1),
      .rsp_valid(rv_1), .rsp_rdata(rd_1), .rsp_err(err_1)
   );

   function automatic logic ready_of(input int s);
      return (s == 1) ? rdy_1 : rdy_0;
   endfunction
   function automatic logic rsp_valid_of(input int s);
      return (s == 1) ? rv_1 : rv_0;
   endfunction
   function automatic logic rsp_err_of(input int s);
      return (s == 1) ? err_1 : err_0;
   endfunction
   function automatic logic [31:0] rdata_of(input int s);
      return (s == 1) ? rd_1 : rd_0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int s, input logic v, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
      if (s == 1) begin
         v_1 = v; we_1 = we; f3_1 = f3; a_1 = a; d_1 = d;
      end else begin
         v_0 = v; we_0 = we; f3_0 = f3; a_0 = a; d_0 = d;
      end
   endtask

   task automatic drop_valid(input int s);
      if (s == 1) v_1 = 1'b0;
      else        v_0 = 1'b0;
   endtask

   // Rules for rejecting a request, stated on the byte address.
   function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
      int size;
      size = 1 << f3[1:0];
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
      if (we && f3 >= 3'd4) return 1'b1;
      if ((a % size) != 0) return 1'b1;
      if ((a / 4) >= 256) return 1'b1;
      return 1'b0;
   endfunction

   // Apply a request to the reference memory and return the expected response.
   task automatic model_apply(input int s, input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] exp_rd, output logic exp_err);
      int size;
      longint v;
      size    = 1 << f3[1:0];
      exp_err = model_err(we, f3, a);
      exp_rd  = 32'd0;
      if (!exp_err) begin
         if (we) begin
            for (int i = 0; i < size; i++) bmem[s][a + i] = 8'(d >> (8 * i));
         end else begin
            v = 0;
            for (int i = 0; i < size; i++) v = v | (longint'(bmem[s][a + i]) << (8 * i));
            if (!f3[2] && size < 4 && v[8 * size - 1]) v = v - (longint'(1) << (8 * size));
            exp_rd = v[31:0];
         end
      end
   endtask

   // One complete transaction: present, wait for accept, time the response,
   // compare it against the model, then confirm the response has gone away.
   task automatic run(input int s, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d,
                      input string tag, output logic [31:0] got);
      logic [31:0] exp_rd;
      logic        exp_err;
      int          guard;
      int          lat;
      model_apply(s, we, f3, a, d, exp_rd, exp_err);
      @(negedge clk);
      drive(s, 1'b1, we, f3, a, d);
      guard = 0;
      while (!ready_of(s) && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check({tag, "_ready"}, 32'(ready_of(s)), 32'd1);
      @(posedge clk);
      #1 drop_valid(s);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid_of(s) && lat < 40);
      got = rdata_of(s);
      check({tag, "_lat"},   32'(lat), 32'(s + 1));
      check({tag, "_rdata"}, got, exp_rd);
      check({tag, "_err"},   32'(rsp_err_of(s)), 32'(exp_err));
      @(negedge clk);
      check({tag, "_pulse_end"}, 32'(rsp_valid_of(s)), 32'd0);
      check({tag, "_rdata_idle"}, rdata_of(s), 32'd0);
   endtask

   // Global time bound.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] got;
      int          s;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] d;

      // Reset state.
      repeat (2) @(posedge clk);
      #2;
      check("rst_ready_w1", 32'(rdy_1), 32'd0);
      check("rst_valid_w1", 32'(rv_1),  32'd0);
      check("rst_rdata_w1", rd_1,       32'd0);
      check("rst_err_w1",   32'(err_1), 32'd0);
      check("rst_ready_w0", 32'(rdy_0), 32'd0);
      check("rst_valid_w0", 32'(rv_0),  32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1 check("rel_ready_w1", 32'(rdy_1), 32'd1);

      // Word store and load back.
      run(1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "t1_sw", got);
      run(1, 1'b0, 3'b010, 32'h10, 32'h0, "t1_lw", got);
      check("t1_lw_value", got, 32'hDEADBEEF);

      // Sub-word loads with sign/zero extension.
      run(1, 1'b0, 3'b000, 32'h13, 32'h0, "t2_lb", got);
      check("t2_lb_value", got, 32'hFFFFFFDE);
      run(1, 1'b0, 3'b100, 32'h13, 32'h0, "t2_lbu", got);
      check("t2_lbu_value", got, 32'h000000DE);
      run(1, 1'b0, 3'b001, 32'h12, 32'h0, "t2_lh", got);
      check("t2_lh_value", got, 32'hFFFFDEAD);
      run(1, 1'b0, 3'b101, 32'h10, 32'h0, "t2_lhu", got);
      check("t2_lhu_value", got, 32'h0000BEEF);

      // Byte and half stores touch only their lanes.
      run(1, 1'b1, 3'b000, 32'h11, 32'h123456AA, "t3_sb", got);
      run(1, 1'b0, 3'b010, 32'h10, 32'h0, "t3_lw_a", got);
      check("t3_after_sb", got, 32'hDEADAAEF);
      run(1, 1'b1, 3'b001, 32'h12, 32'h00007777, "t3_sh", got);
      run(1, 1'b0, 3'b010, 32'h10, 32'h0, "t3_lw_b", got);
      check("t3_after_sh", got, 32'h7777AAEF);

      // Rejected requests.
      run(1, 1'b0, 3'b010, 32'h12, 32'h0, "t4_lw_mis", got);
      check("t4_lw_mis_err", 32'(err_1), 32'd0);
      run(1, 1'b1, 3'b001, 32'h11, 32'hFFFFFFFF, "t4_sh_mis", got);
      run(1, 1'b0, 3'b011, 32'h10, 32'h0, "t4_f3_011", got);
      run(1, 1'b1, 3'b100, 32'h10, 32'h0, "t4_store_bu", got);
      run(1, 1'b1, 3'b010, 32'd1024, 32'h0BADF00D, "t4_sw_range", got);
      run(1, 1'b0, 3'b010, 32'd1024, 32'h0, "t4_lw_range", got);
      run(1, 1'b0, 3'b010, 32'h10, 32'h0, "t4_lw_check", got);
      check("t4_unchanged", got, 32'h7777AAEF);

      // No wait states: request held high is accepted every other cycle.
      run(0, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, "t5_sw", got);
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
      for (int i = 0; i < 8; i++) begin
         check("t5_ready", 32'(rdy_0), 32'((i % 2) == 0));
         check("t5_valid", 32'(rv_0),  32'((i % 2) == 1));
         if ((i % 2) == 1) check("t5_rdata", rd_0, 32'hCAFEF00D);
         @(negedge clk);
      end
      drop_valid(0);

      // Reset during WAIT drops the pending store and its response.
      run(1, 1'b1, 3'b010, 32'h20, 32'h11223344, "t6_pre", got);
      @(negedge clk);
      drive(1, 1'b1, 1'b1, 3'b010, 32'h20, 32'h00000055);
      @(posedge clk);
      #1 drop_valid(1);
      #2 reset_n = 1'b0;
      #1 check("t6_ready_in_rst", 32'(rdy_1), 32'd0);
      repeat (3) begin
         @(negedge clk);
         check("t6_no_rsp_in_rst", 32'(rv_1), 32'd0);
      end
      reset_n = 1'b1;
      #1 check("t6_ready_after", 32'(rdy_1), 32'd1);
      repeat (3) begin
         @(negedge clk);
         check("t6_no_rsp_after", 32'(rv_1), 32'd0);
      end
      run(1, 1'b0, 3'b010, 32'h20, 32'h0, "t6_lw", got);
      check("t6_old_value", got, 32'h11223344);

      // Randomized traffic against the reference memory.
      for (int w = 0; w < 16; w++) begin
         run(0, 1'b1, 3'b010, 32'(4 * w), $urandom, "pre_w0", got);
         run(1, 1'b1, 3'b010, 32'(4 * w), $urandom, "pre_w1", got);
      end
      for (int k = 0; k < 60; k++) begin
         s  = int'($urandom_range(0, 1));
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) a = 32'd1024 + 32'($urandom_range(0, 4095));
         else                           a = 32'($urandom_range(0, 63));
         d  = $urandom;
         run(s, we, f3, a, d, "rnd", got);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
